program_counter: RTL



---
 rtl/cpu65_pkg.sv | 22 ++
 rtl/pc_branch_adder.sv | 23 ++
 rtl/program_counter.sv | 104 ++++++++++
 3 files changed

// File: rtl/cpu65_pkg.sv
// Shared 65C02 core types: program counter operation codes, PC sequencer
// states and the reset vector address.
package cpu65_pkg;

   typedef enum logic [2:0] {
      PC_HOLD         = 3'b000,
      PC_INC          = 3'b001,
      PC_LOAD_BUS     = 3'b010,
      PC_LOAD_BUS_INC = 3'b011,
      PC_BRANCH       = 3'b100,
      PC_LOAD_LOW     = 3'b101,
      PC_LOAD_HIGH    = 3'b110
   } pc_op_t;

   typedef enum logic {
      PC_IDLE  = 1'b0,
      PC_FIXUP = 1'b1
   } pc_state_t;

   localparam logic [15:0] PC_RESET_VECTOR = 16'hFFFC;

endpackage

// File: rtl/pc_branch_adder.sv
// Combinational 8-bit relative-branch adder: adds a signed offset to a low
// address byte and reports whether the high byte needs a follow-up fixup,
// and in which direction.
module pc_branch_adder (
   input  logic [7:0] pcl,
   input  logic [7:0] offset,
   output logic [7:0] new_pcl,
   output logic       fixup_needed,
   output logic       fixup_dec
);

   logic [8:0] sum;

   // A positive offset crosses a page when it carries out; a negative offset
   // (two's complement) crosses when it does NOT carry out.
   always_comb begin
      sum          = {1'b0, pcl} + {1'b0, offset};
      new_pcl      = sum[7:0];
      fixup_dec    = offset[7];
      fixup_needed = sum[8] ^ offset[7];
   end

endmodule

// File: rtl/program_counter.sv
// 16-bit program counter stage feeding the address bus PC source.
// Handshake: rdy is a hold qualifier, not a request/acknowledge pair. On a
// rising phi2 edge with rdy=1 the stage consumes pc_op (IDLE) or completes
// the pending page fixup (FIXUP); with rdy=0 every register holds and pc_op
// is ignored. While fixup_busy=1 the sequencer must not issue a new pc_op;
// any op presented then is ignored.
module program_counter
   import cpu65_pkg::*;
#(
   parameter logic [15:0] RESET_PC = PC_RESET_VECTOR
) (
   input  logic        phi2,
   input  logic        resb,
   input  logic        rdy,
   input  logic [2:0]  pc_op,
   input  logic [7:0]  pcl_bus_in,
   input  logic [7:0]  pch_bus_in,
   input  logic [7:0]  data_in,
   output logic [7:0]  PCL_out,
   output logic [7:0]  PCH_out,
   output logic [15:0] pc_full,
   output logic        fixup_busy,
   output logic        page_cross
);

   pc_state_t   state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [7:0]  staged_q, staged_d;
   logic        dir_dec_q, dir_dec_d;
   logic        page_cross_q, page_cross_d;

   logic [7:0]  branch_pcl;
   logic        branch_fixup;
   logic        branch_dec;

   pc_branch_adder u_branch_adder (
      .pcl          (pc_q[7:0]),
      .offset       (data_in),
      .new_pcl      (branch_pcl),
      .fixup_needed (branch_fixup),
      .fixup_dec    (branch_dec)
   );

   // State register: PC, FSM state, staged vector byte, fixup direction and page_cross pulse.
   always_ff @(posedge phi2 or negedge resb) begin
      if (!resb) begin
         state_q      <= PC_IDLE;
         pc_q         <= RESET_PC;
         staged_q     <= 8'h00;
         dir_dec_q    <= 1'b0;
         page_cross_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         staged_q     <= staged_d;
         dir_dec_q    <= dir_dec_d;
         page_cross_q <= page_cross_d;
      end
   end

   // Next-state logic: everything holds unless rdy=1; FIXUP adjusts PCH and ignores pc_op.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      staged_d     = staged_q;
      dir_dec_d    = dir_dec_q;
      page_cross_d = page_cross_q;
      if (rdy) begin
         page_cross_d = 1'b0;
         case (state_q)
            PC_FIXUP: begin
               pc_d[15:8]   = dir_dec_q ? (pc_q[15:8] - 8'd1) : (pc_q[15:8] + 8'd1);
               page_cross_d = 1'b1;
               state_d      = PC_IDLE;
            end
            default: begin
               case (pc_op_t'(pc_op))
                  PC_INC:          pc_d = pc_q + 16'd1;
                  PC_LOAD_BUS:     pc_d = {pch_bus_in, pcl_bus_in};
                  PC_LOAD_BUS_INC: pc_d = {pch_bus_in, pcl_bus_in} + 16'd1;
                  PC_BRANCH: begin
                     pc_d[7:0] = branch_pcl;
                     if (branch_fixup) begin
                        state_d   = PC_FIXUP;
                        dir_dec_d = branch_dec;
                     end
                  end
                  PC_LOAD_LOW:     staged_d = data_in;
                  PC_LOAD_HIGH:    pc_d = {data_in, staged_q};
                  default:         pc_d = pc_q;
               endcase
            end
         endcase
      end
   end

   // All outputs come straight from registers.
   assign PCL_out    = pc_q[7:0];
   assign PCH_out    = pc_q[15:8];
   assign pc_full    = pc_q;
   assign fixup_busy = (state_q == PC_FIXUP);
   assign page_cross = page_cross_q;

endmodule
